// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encoding, geometry derivations and address-field helpers
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_CMP, S_RF_REQ, S_RF_DATA, S_WT_REQ, S_WT_ACK, S_RESP
  } cache_state_e;

  localparam int ADDR_LSB = 3;

  function automatic int calc_line_w(input int dw, input int bk);
    return $clog2(dw * bk / 8);
  endfunction

  function automatic int calc_tag_w(input int dw, input int bk, input int cl);
    return 32 - calc_line_w(dw, bk) - $clog2(cl);
  endfunction

  function automatic int calc_beats(input int dw, input int bk);
    return dw * bk / 64;
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int line_w, input int idx_w);
    return addr >> (line_w + idx_w);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int line_w, input int idx_w);
    return (addr >> line_w) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_bank(input logic [31:0] addr, input int dw, input int bk);
    return (addr >> $clog2(dw / 8)) & 32'(bk - 1);
  endfunction

  function automatic logic [31:0] addr_word(input logic [31:0] addr, input int line_w);
    return (addr & ((32'd1 << line_w) - 32'd1)) >> ADDR_LSB;
  endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// rtl/cache_victim_sel.sv - refill victim way: lowest invalid way first, else round-robin pointer
module cache_victim_sel
  import cache_pkg::*;
#(
  parameter int CB = 1,
  localparam int WAY_W = (CB > 1) ? $clog2(CB) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [CB-1:0]    valid_row,
  input  logic             advance,
  output logic [WAY_W-1:0] victim
);

  logic [WAY_W-1:0] rr_q;
  logic             found;

  always_comb begin
    victim = rr_q;
    found  = 1'b0;
    for (int w = 0; w < CB; w++) begin
      if (!found && !valid_row[w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_q <= '0;
    end else if (advance) begin
      rr_q <= (rr_q == WAY_W'(CB - 1)) ? '0 : rr_q + WAY_W'(1);
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - cache sequencer: lookup, read-miss line refill, write-through stores
// Optional hit/miss counters are built when CACHE_CTRL_PERF_EN is defined.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int DW = 1024,
  parameter int BK = 4,
  parameter int CB = 1,
  parameter int CL = 256,
  localparam int TAG_W = calc_tag_w(DW, BK, CL)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_addr,
  input  logic                req_wen,
  input  logic [63:0]         req_wdata,
  input  logic [7:0]          req_wstrb,
  output logic                rsp_valid,
  output logic [63:0]         rsp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [31:0]         mem_req_addr,
  output logic                mem_req_wen,
  output logic [63:0]         mem_req_wdata,
  output logic [7:0]          mem_req_wstrb,
  input  logic                mem_rsp_valid,
  input  logic [63:0]         mem_rsp_data,
  output logic [31:0]         cache_addr,
  output logic [CB-1:0]       cache_en_w,
  output logic [CB-1:0]       cache_en_r,
  output logic [7:0]          cache_info_wstrb,
  output logic [63:0]         cache_info_w,
  input  logic [64*CB-1:0]    cache_info_r,
  output logic [31:0]         tag_addr,
  output logic [CB-1:0]       tag_en_w,
  output logic [CB-1:0]       tag_en_r,
  output logic [TAG_W-1:0]    tag_info_w,
  input  logic [TAG_W*CB-1:0] tag_info_r,
  output logic [31:0]         perf_hit_cnt,
  output logic [31:0]         perf_miss_cnt
);

  localparam int LINE_W = calc_line_w(DW, BK);
  localparam int IDX_W  = $clog2(CL);
  localparam int BEATS  = calc_beats(DW, BK);
  localparam int CNT_W  = $clog2(BEATS);
  localparam int WAY_W  = (CB > 1) ? $clog2(CB) : 1;
  localparam logic [31:0] LINE_MASK = (32'd1 << LINE_W) - 32'd1;

  cache_state_e     state_q, state_d;
  logic [31:0]      addr_q;
  logic             wen_q;
  logic [63:0]      wdata_q, rdata_q;
  logic [7:0]       wstrb_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WAY_W-1:0] victim_q, victim, hit_way;
  logic [CL-1:0]    valid_q [CB];
  logic [CB-1:0]    valid_row;
  logic             hit_any, miss_rd, last_beat;

  logic [TAG_W-1:0] cur_tag;
  logic [IDX_W-1:0] cur_idx;
  logic [CNT_W-1:0] cur_word;
  logic [31:0]      line_base;

  assign cur_tag   = TAG_W'(addr_tag(addr_q, LINE_W, IDX_W));
  assign cur_idx   = IDX_W'(addr_index(addr_q, LINE_W, IDX_W));
  assign cur_word  = CNT_W'(addr_word(addr_q, LINE_W));
  assign line_base = addr_q & ~LINE_MASK;
  assign last_beat = mem_rsp_valid && (cnt_q == CNT_W'(BEATS - 1));
  assign miss_rd   = (state_q == S_CMP) && !hit_any && !wen_q;

  // Descending scan so the lowest-index way wins if several ever match.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = CB - 1; w >= 0; w--) begin
      valid_row[w] = valid_q[w][cur_idx];
      if (valid_q[w][cur_idx] && tag_info_r[w*TAG_W +: TAG_W] == cur_tag) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  cache_victim_sel #(.CB(CB)) u_victim (
    .CLK       (CLK),
    .RST       (RST),
    .valid_row (valid_row),
    .advance   (miss_rd),
    .victim    (victim)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    req_ready        = 1'b0;
    rsp_valid        = 1'b0;
    rsp_rdata        = '0;
    mem_req_valid    = 1'b0;
    mem_req_addr     = '0;
    mem_req_wen      = 1'b0;
    mem_req_wdata    = '0;
    mem_req_wstrb    = '0;
    cache_addr       = addr_q;
    cache_en_w       = '0;
    cache_en_r       = '0;
    cache_info_wstrb = '0;
    cache_info_w     = '0;
    tag_addr         = addr_q;
    tag_en_w         = '0;
    tag_en_r         = '0;
    tag_info_w       = '0;
    case (state_q)
      S_IDLE: begin
        req_ready  = 1'b1;
        cache_addr = req_addr;
        tag_addr   = req_addr;
        if (req_valid) begin
          cache_en_r = '1;
          tag_en_r   = '1;
          state_d    = S_CMP;
        end
      end
      S_CMP: begin
        if (hit_any && !wen_q) begin
          rsp_valid = 1'b1;
          rsp_rdata = cache_info_r[int'(hit_way)*64 +: 64];
          state_d   = S_IDLE;
        end else if (wen_q) begin
          if (hit_any) begin
            cache_en_w[hit_way] = 1'b1;
            cache_info_w        = wdata_q;
            cache_info_wstrb    = wstrb_q;
          end
          state_d = S_WT_REQ;
        end else begin
          state_d = S_RF_REQ;
        end
      end
      S_RF_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = line_base;
        if (mem_req_ready) state_d = S_RF_DATA;
      end
      S_RF_DATA: begin
        cache_addr = line_base | (32'(cnt_q) << ADDR_LSB);
        if (mem_rsp_valid) begin
          cache_en_w[victim_q] = 1'b1;
          cache_info_w         = mem_rsp_data;
          cache_info_wstrb     = 8'hFF;
          if (last_beat) begin
            tag_en_w[victim_q] = 1'b1;
            tag_info_w         = cur_tag;
            state_d            = S_RESP;
          end
        end
      end
      S_WT_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_wen   = 1'b1;
        mem_req_addr  = addr_q & ~32'h7;
        mem_req_wdata = wdata_q;
        mem_req_wstrb = wstrb_q;
        if (mem_req_ready) state_d = S_WT_ACK;
      end
      S_WT_ACK: begin
        if (mem_rsp_valid) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The victim's valid bit drops at the miss and only returns with the last beat,
  // so an interrupted refill leaves the line invalid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      victim_q <= '0;
      for (int w = 0; w < CB; w++) valid_q[w] <= '0;
    end else begin
      if (state_q == S_IDLE && req_valid) begin
        addr_q  <= req_addr;
        wen_q   <= req_wen;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        rdata_q <= '0;
      end
      if (miss_rd) begin
        valid_q[victim][cur_idx] <= 1'b0;
        victim_q                 <= victim;
      end
      if (state_q == S_RF_REQ && mem_req_ready) cnt_q <= '0;
      if (state_q == S_RF_DATA && mem_rsp_valid) begin
        if (cnt_q == cur_word) rdata_q <= mem_rsp_data;
        if (last_beat) begin
          cnt_q                      <= '0;
          valid_q[victim_q][cur_idx] <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

`ifdef CACHE_CTRL_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_CMP) begin
      if (hit_any && hit_cnt_q != 32'hFFFF_FFFF)   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (!hit_any && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign perf_hit_cnt  = hit_cnt_q;
  assign perf_miss_cnt = miss_cnt_q;
`else
  assign perf_hit_cnt  = '0;
  assign perf_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - scoreboard bench for cache_ctrl with behavioural tag/data arrays and memory
module tb_cache_ctrl;

  localparam int TAG_W = 15;

  typedef struct {
    int          kind;   // 0: no latency check, 1: hit latency, 2: refill latency
    logic [63:0] rdata;
  } rsp_t;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [7:0]  strb;
    logic [63:0] wdata;
  } mreq_t;

  logic CLK = 1'b0;
  logic rst_init = 1'b1, rst_abort = 1'b0;
  logic RST;
  assign RST = rst_init | rst_abort;

  logic             req_valid, req_ready, req_wen;
  logic [31:0]      req_addr;
  logic [63:0]      req_wdata;
  logic [7:0]       req_wstrb;
  logic             rsp_valid;
  logic [63:0]      rsp_rdata;
  logic             mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0]      mem_req_addr;
  logic [63:0]      mem_req_wdata;
  logic [7:0]       mem_req_wstrb;
  logic             mem_rsp_valid;
  logic [63:0]      mem_rsp_data;
  logic [31:0]      cache_addr, tag_addr;
  logic [0:0]       cache_en_w, cache_en_r, tag_en_w, tag_en_r;
  logic [7:0]       cache_info_wstrb;
  logic [63:0]      cache_info_w, cache_info_r;
  logic [TAG_W-1:0] tag_info_w, tag_info_r;
  logic [31:0]      perf_hit_cnt, perf_miss_cnt;

  int    checks = 0, errors = 0, cyc = 0;
  int    acc_cyc = 0, last_beat_cyc = 0, abort_at = -1;
  logic  abort_done = 1'b0;
  rsp_t  exp_rsp[$];
  mreq_t exp_mem[$];

  cache_ctrl dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .cache_addr(cache_addr), .cache_en_w(cache_en_w), .cache_en_r(cache_en_r),
    .cache_info_wstrb(cache_info_wstrb), .cache_info_w(cache_info_w), .cache_info_r(cache_info_r),
    .tag_addr(tag_addr), .tag_en_w(tag_en_w), .tag_en_r(tag_en_r),
    .tag_info_w(tag_info_w), .tag_info_r(tag_info_r),
    .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Direct-mapped arrays for the default geometry: 256 sets x 64 words, 1-cycle read.
  logic [63:0]      dmem [16384];
  logic [TAG_W-1:0] tmem [256];

  always @(posedge CLK) begin
    if (cache_en_r[0]) cache_info_r <= dmem[cache_addr[16:3]];
    if (tag_en_r[0])   tag_info_r   <= tmem[tag_addr[16:9]];
    if (cache_en_w[0])
      for (int b = 0; b < 8; b++)
        if (cache_info_wstrb[b]) dmem[cache_addr[16:3]][b*8 +: 8] <= cache_info_w[b*8 +: 8];
    if (tag_en_w[0]) tmem[tag_addr[16:9]] <= tag_info_w;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic serve();
    mreq_t e;
    logic  w;
    w = mem_req_wen;
    checks++;
    if (exp_mem.size() == 0) begin
      errors++;
      $display("FAIL mem_req_unexpected: got wen=%0b addr=%h, required no request", mem_req_wen, mem_req_addr);
    end else begin
      e = exp_mem.pop_front();
      if (mem_req_wen !== e.wen || mem_req_addr !== e.addr ||
          (e.wen && (mem_req_wstrb !== e.strb || mem_req_wdata !== e.wdata))) begin
        errors++;
        $display("FAIL mem_req: got wen=%0b addr=%h strb=%h data=%h, required wen=%0b addr=%h strb=%h data=%h",
                 mem_req_wen, mem_req_addr, mem_req_wstrb, mem_req_wdata, e.wen, e.addr, e.strb, e.wdata);
      end
    end
    mem_req_ready = 1'b1;
    @(negedge CLK);
    mem_req_ready = 1'b0;
    if (w) begin
      @(negedge CLK);
      mem_rsp_valid = 1'b1;
      @(negedge CLK);
      mem_rsp_valid = 1'b0;
    end else begin
      for (int b = 0; b < 64; b++) begin
        if (b == abort_at) begin
          rst_abort = 1'b1;
          @(negedge CLK);
          checks++;
          if (!(req_ready === 1'b1 && mem_req_valid === 1'b0)) begin
            errors++;
            $display("FAIL abort_idle: got req_ready=%0b mem_req_valid=%0b, required 1 and 0", req_ready, mem_req_valid);
          end
          rst_abort  = 1'b0;
          abort_done = 1'b1;
          return;
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'(b);
        if (b == 63) last_beat_cyc = cyc;
        @(negedge CLK);
        mem_rsp_valid = 1'b0;
      end
    end
  endtask

  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(negedge CLK);
      if (!RST && mem_req_valid) serve();
    end
  end

  // Response monitor: every rsp_valid pulse is matched against the oldest expectation.
  always @(negedge CLK) begin
    if (!RST && rsp_valid) begin
      checks++;
      if (exp_rsp.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got rdata=%h, required no response", rsp_rdata);
      end else begin
        rsp_t e;
        e = exp_rsp.pop_front();
        if (rsp_rdata !== e.rdata) begin
          errors++;
          $display("FAIL rsp_rdata: got %h, required %h", rsp_rdata, e.rdata);
        end
        if (e.kind == 1) begin
          checks++;
          if (cyc != acc_cyc + 1) begin
            errors++;
            $display("FAIL hit_latency: got %0d cycles, required 1", cyc - acc_cyc);
          end
        end else if (e.kind == 2) begin
          checks++;
          if (cyc != last_beat_cyc + 1) begin
            errors++;
            $display("FAIL refill_latency: got %0d cycles after last beat, required 1", cyc - last_beat_cyc);
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic w, input logic [63:0] d, input logic [7:0] s);
    int n = 0;
    @(negedge CLK);
    req_valid = 1'b1; req_addr = a; req_wen = w; req_wdata = d; req_wstrb = s;
    while (!req_ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_accept_timeout: got req_ready=0, required 1 within 200 cycles");
    end
    acc_cyc = cyc;
    @(negedge CLK);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_rsp.size() != 0 || exp_mem.size() != 0) && n < 400) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL txn_timeout: got %0d rsp / %0d mem pending, required 0", exp_rsp.size(), exp_mem.size());
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic read_op(input logic [31:0] a, input int kind, input logic [63:0] d);
    if (kind == 2) exp_mem.push_back('{1'b0, a & ~32'h1FF, 8'h00, 64'h0});
    exp_rsp.push_back('{kind, d});
    issue(a, 1'b0, 64'h0, 8'h00);
    wait_done();
  endtask

  task automatic store_op(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    exp_mem.push_back('{1'b1, a, s, d});
    exp_rsp.push_back('{0, 64'h0});
    issue(a, 1'b1, d, s);
    wait_done();
  endtask

  initial begin
    int n;
    req_valid = 1'b0; req_addr = '0; req_wen = 1'b0; req_wdata = '0; req_wstrb = '0;
    repeat (3) @(negedge CLK);
    chk("reset_req_ready", 64'(req_ready), 64'h1);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset_mem_req_valid", 64'(mem_req_valid), 64'h0);
    chk("reset_perf_hit", 64'(perf_hit_cnt), 64'h0);
    chk("reset_perf_miss", 64'(perf_miss_cnt), 64'h0);
    rst_init = 1'b0;

    read_op(32'h8000_0040, 2, 64'd8);
    read_op(32'h8000_0048, 1, 64'd9);
    store_op(32'h8000_0048, 64'hAA, 8'h01);
    read_op(32'h8000_0048, 1, 64'hAA);
    store_op(32'h9000_0000, 64'h1234_5678_9ABC_DEF0, 8'hFF);
    read_op(32'h9000_0000, 2, 64'd0);
    read_op(32'h8002_0040, 2, 64'd8);
    read_op(32'h8000_0040, 2, 64'd8);
    read_op(32'h8000_0040, 1, 64'd8);
`ifdef CACHE_CTRL_PERF_EN
    chk("perf_hit_total", 64'(perf_hit_cnt), 64'd4);
    chk("perf_miss_total", 64'(perf_miss_cnt), 64'd5);
`else
    chk("perf_hit_off", 64'(perf_hit_cnt), 64'd0);
    chk("perf_miss_off", 64'(perf_miss_cnt), 64'd0);
`endif

    exp_mem.push_back('{1'b0, 32'h8004_0000, 8'h00, 64'h0});
    abort_at = 30;
    issue(32'h8004_0010, 1'b0, 64'h0, 8'h00);
    n = 0;
    while (!abort_done && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!abort_done) begin
      checks++; errors++;
      $display("FAIL abort_timeout: got no reset at beat 30, required one within 200 cycles");
    end
    abort_at = -1;
    @(negedge CLK);
    chk("abort_perf_hit", 64'(perf_hit_cnt), 64'h0);
    chk("abort_perf_miss", 64'(perf_miss_cnt), 64'h0);
    read_op(32'h8004_0010, 2, 64'd2);
    read_op(32'h8004_0018, 1, 64'd3);
`ifdef CACHE_CTRL_PERF_EN
    chk("perf_hit_after_rst", 64'(perf_hit_cnt), 64'd1);
    chk("perf_miss_after_rst", 64'(perf_miss_cnt), 64'd1);
`endif
    chk("rsp_queue_drained", 64'(exp_rsp.size()), 64'h0);
    chk("mem_queue_drained", 64'(exp_mem.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
